alarm_set_multi: RTL
====================

Name: alarm_set_multi

Overview:
- Parametrised successor to the single-alarm adjust block. Manages the clock-set value and NUM_ALARMS independent alarm times.
- Provides a cursor over all hour/minute fields, BCD up/down with wrap, per-alarm enable bits, alarm match/ring detection and a one-cycle load strobe to the timekeeper.
- Sits between the debounced button front end and the timekeeper/7-segment display mux.

Parameters:
NUM_ALARMS, 2, number of alarm channels (1..4)
SNOOZE_MIN, 5, snooze length in minutes (1..59); used only with SNOOZE_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
en  in  1  adjust mode (1 = editing)
bt_u, bt_d, bt_r, bt_l, bt_c  in  1 each  debounced single-cycle button pulses
cur_HT, cur_HU, cur_MT, cur_MU  in  4 each  running time from timekeeper, BCD
HT_disp, HU_disp, MT_disp, MU_disp  out  4 each  digits to display
set_HT, set_HU, set_MT, set_MU  out  4 each  clock-set value
set_ld  out  1  one-cycle strobe: timekeeper loads set_*
leds  out  2*(NUM_ALARMS+1)  one-hot cursor indicator
alarm_on  out  NUM_ALARMS  alarm enable bits
ring  out  NUM_ALARMS  latched ringing flags
dot  out  1  colon indicator

Behaviour:
- Fields F = 2*(NUM_ALARMS+1). Cursor 0 = clock hours, 1 = clock minutes, 2k+2 = alarm k hours, 2k+3 = alarm k minutes.
- Reset (reset == 0 at clk edge): cursor 0, all alarm registers 00:00, alarm_on 0, ring 0, set_* 00:00, set_ld 0, dirty flag 0, en_d 0. Reset has priority over all inputs, including mid-edit; no set_ld is issued.
- en rising (en = 1, en_d = 0): set_* load from cur_*, dirty cleared, cursor to 0.
- While en = 1:
  - bt_r moves cursor +1 mod F; bt_l moves it -1 mod F. Both together: no move.
  - bt_u increments the selected field; bt_d decrements it. Both together: no change.
  - Hours wrap 23->00 and 00->23. Minutes wrap 59->00 and 00->59.
  - BCD is kept legal: a units carry or borrow ripples into the tens digit. Tens digit is never above 2 for hours or 5 for minutes.
  - An edit of field 0 or 1 sets dirty.
  - bt_c on an alarm field toggles that alarm's alarm_on bit; bt_c on a clock field does nothing.
  - All edits are registered and visible on outputs one cycle after the pulse.
- en falling (en = 0, en_d = 1): if dirty, set_ld = 1 for exactly one cycle the next cycle; dirty cleared. Buttons during that cycle act in run mode.
- Display: en = 1 shows the HH:MM of the target owning the cursor. en = 0 passes through cur_* (combinational). dot = 1 when en = 0; dot = 0 when en = 1.
- leds: bit cursor = 1, others 0 when en = 1; all 0 when en = 0.
- Match[k] = alarm_on[k] && cur_* == alarm k value && en == 0.
  - ring[k] sets the cycle after a rising edge of match[k]; a continuous match does not re-set it after clearing.
  - ring clears on bt_c while en = 0 (all channels), when en rises, or when alarm_on[k] is toggled off.
  - A simultaneous set event and bt_c: clear wins.

Optional Feature:
- Macro: SNOOZE_EN.
- Defined: bt_d while en = 0 and any ring bit set clears ring and arms a snooze target per ringing channel = cur time + SNOOZE_MIN minutes, BCD, with hour and 23:59->00:xx wrap. When cur_* equals the snooze target, that channel's ring sets again and the snooze disarms. Snooze disarms on bt_c, on en rise, or on alarm_on[k] cleared.
- Not defined: no snooze registers exist; bt_d in run mode has no effect.

Test Plan:
- Reset low 1 cycle, then en = 1 with cur = 12:34 -> HT/HU/MT/MU_disp = 1,2,3,4; leds = 000001; alarm_on = 00; ring = 00.
- en = 1, cursor 0 at 23, bt_u pulse -> hours 00. bt_d pulse -> 23. Cursor 1 at 59, bt_u -> 00. Release en -> set_ld high exactly 1 cycle with set = 23:00.
- bt_r x6 with NUM_ALARMS = 2 -> cursor wraps to 0. bt_l from 0 -> 5. bt_r and bt_l together -> cursor unchanged.
- Alarm 1 set to 07:15, bt_c on field 4 -> alarm_on = 10. en = 0; cur steps 07:14->07:15 -> ring = 10 next cycle; bt_c -> ring = 00; cur held at 07:15 -> no re-ring.
- Mid-edit (en = 1, clock edited, dirty), reset low -> all outputs at reset values; en dropped afterwards -> no set_ld.
- SNOOZE_EN, SNOOZE_MIN = 5, ring on at 23:58, bt_d -> ring cleared; cur 00:03 -> ring re-asserts.

Source files
------------

// File: rtl/alarm_set_multi.sv
// Purpose: clock-set and NUM_ALARMS alarm editor (cursor, BCD up/down, alarm enables, ring, load strobe); optional snooze with SNOOZE_EN.
// Latency: edits, ring, alarm_on and set_ld are registered (1 cycle); display, dot and leds follow en combinationally.
// Backpressure: none; single-cycle button pulses are consumed in the cycle they arrive.
module alarm_set_multi #(
  parameter int NUM_ALARMS = 2,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          bt_u,
  input  logic                          bt_d,
  input  logic                          bt_r,
  input  logic                          bt_l,
  input  logic                          bt_c,
  input  logic [3:0]                    cur_HT,
  input  logic [3:0]                    cur_HU,
  input  logic [3:0]                    cur_MT,
  input  logic [3:0]                    cur_MU,
  output logic [3:0]                    HT_disp,
  output logic [3:0]                    HU_disp,
  output logic [3:0]                    MT_disp,
  output logic [3:0]                    MU_disp,
  output logic [3:0]                    set_HT,
  output logic [3:0]                    set_HU,
  output logic [3:0]                    set_MT,
  output logic [3:0]                    set_MU,
  output logic                          set_ld,
  output logic [2*(NUM_ALARMS+1)-1:0]   leds,
  output logic [NUM_ALARMS-1:0]         alarm_on,
  output logic [NUM_ALARMS-1:0]         ring,
  output logic                          dot
);

  // Target 0 is the clock-set value, target k+1 is alarm k.
  localparam int T  = NUM_ALARMS + 1;
  localparam int F  = 2 * T;
  localparam int CW = $clog2(F);

  // Named marker that appears in the elaborated hierarchy for unsupported configurations.
  if (NUM_ALARMS < 1 || NUM_ALARMS > 4 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_cfg_out_of_range
  end

  // BCD hour step with 23<->00 wrap; units carry/borrow ripples into tens.
  function automatic logic [7:0] hr_step(input logic [7:0] v, input logic up);
    logic [7:0] r;
    if (up) begin
      if (v == 8'h23)             r = 8'h00;
      else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
      else                        r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)             r = 8'h23;
      else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
      else                        r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // BCD minute step with 59<->00 wrap.
  function automatic logic [7:0] mn_step(input logic [7:0] v, input logic up);
    logic [7:0] r;
    if (up) begin
      if (v == 8'h59)             r = 8'h00;
      else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
      else                        r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)             r = 8'h59;
      else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
      else                        r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  logic [CW-1:0]         cursor;
  logic [CW-1:0]         cursor_nx;
  logic [CW-1:0]         sel;
  logic [7:0]            hr_q [T];
  logic [7:0]            mn_q [T];
  logic                  en_d;
  logic                  dirty;
  logic [NUM_ALARMS-1:0] match_d;

  logic                  en_rise;
  logic                  en_fall;
  logic                  edit_ok;
  logic                  step_up;
  logic                  step_dn;
  logic [7:0]            cur_h;
  logic [7:0]            cur_m;
  logic [7:0]            disp_h;
  logic [7:0]            disp_m;
  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] toggle;
  logic [NUM_ALARMS-1:0] tog_off;
  logic                  ring_clr_all;
  logic [NUM_ALARMS-1:0] snz_hit;
  logic                  snz_clr;

  assign en_rise = en & ~en_d;
  assign en_fall = ~en & en_d;
  // Buttons in the en-rise cycle are ignored so the freshly loaded value is not edited blind.
  assign edit_ok = en & ~en_rise;
  assign step_up = bt_u & ~bt_d;
  assign step_dn = bt_d & ~bt_u;
  assign cur_h   = {cur_HT, cur_HU};
  assign cur_m   = {cur_MT, cur_MU};
  assign sel     = cursor >> 1;

  assign {set_HT, set_HU} = hr_q[0];
  assign {set_MT, set_MU} = mn_q[0];
  assign {HT_disp, HU_disp} = disp_h;
  assign {MT_disp, MU_disp} = disp_m;
  assign dot = ~en;
  assign ring_clr_all = (bt_c & ~en) | en_rise | snz_clr;

  // Cursor next value: right/left with wrap, simultaneous presses cancel.
  always_comb begin
    cursor_nx = cursor;
    if (bt_r && !bt_l)
      cursor_nx = (cursor == CW'(F - 1)) ? '0 : cursor + CW'(1);
    else if (bt_l && !bt_r)
      cursor_nx = (cursor == '0) ? CW'(F - 1) : cursor - CW'(1);
  end

  // Alarm match against running time, and alarm_on toggles from the centre button.
  always_comb begin
    match   = '0;
    toggle  = '0;
    tog_off = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      match[k]   = alarm_on[k] & ~en & (cur_h == hr_q[k+1]) & (cur_m == mn_q[k+1]);
      toggle[k]  = edit_ok & bt_c & (sel == CW'(k + 1));
      tog_off[k] = toggle[k] & alarm_on[k];
    end
  end

  // Display mux: edited target while editing, running time otherwise.
  always_comb begin
    disp_h = cur_h;
    disp_m = cur_m;
    if (en) begin
      for (int t = 0; t < T; t++) begin
        if (sel == CW'(t)) begin
          disp_h = hr_q[t];
          disp_m = mn_q[t];
        end
      end
    end
  end

  // One-hot cursor LEDs, dark in run mode.
  always_comb begin
    leds = '0;
    if (en) begin
      for (int i = 0; i < F; i++) begin
        if (cursor == CW'(i)) leds[i] = 1'b1;
      end
    end
  end

  // Edit state, load strobe and ring flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cursor   <= '0;
      en_d     <= 1'b0;
      dirty    <= 1'b0;
      set_ld   <= 1'b0;
      alarm_on <= '0;
      ring     <= '0;
      match_d  <= '0;
      for (int t = 0; t < T; t++) begin
        hr_q[t] <= 8'h00;
        mn_q[t] <= 8'h00;
      end
    end else begin
      en_d    <= en;
      match_d <= match;
      set_ld  <= en_fall & dirty;
      if (en_rise) begin
        hr_q[0] <= cur_h;
        mn_q[0] <= cur_m;
        cursor  <= '0;
        dirty   <= 1'b0;
      end else if (en) begin
        cursor <= cursor_nx;
        for (int t = 0; t < T; t++) begin
          if (sel == CW'(t) && (step_up || step_dn)) begin
            if (cursor[0]) mn_q[t] <= mn_step(mn_q[t], step_up);
            else           hr_q[t] <= hr_step(hr_q[t], step_up);
          end
        end
        if (sel == '0 && (step_up || step_dn)) dirty <= 1'b1;
        alarm_on <= alarm_on ^ toggle;
      end else if (en_fall) begin
        dirty <= 1'b0;
      end
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (ring_clr_all || tog_off[k])
          ring[k] <= 1'b0;
        else if ((match[k] && !match_d[k]) || snz_hit[k])
          ring[k] <= 1'b1;
      end
    end
  end

`ifdef SNOOZE_EN
  logic [NUM_ALARMS-1:0] snz_arm;
  logic [7:0]            snz_h [NUM_ALARMS];
  logic [7:0]            snz_m [NUM_ALARMS];
  logic                  snz_press;
  logic [6:0]            m_sum;
  logic [4:0]            h_bin;
  logic [7:0]            snz_tgt_h;
  logic [7:0]            snz_tgt_m;

  assign snz_press = ~en & bt_d & (|ring);
  assign snz_clr   = snz_press;

  // Snooze target = running time + SNOOZE_MIN, with hour and midnight wrap.
  always_comb begin
    m_sum = 7'(cur_MT) * 7'd10 + 7'(cur_MU) + 7'(SNOOZE_MIN);
    h_bin = 5'(cur_HT) * 5'd10 + 5'(cur_HU);
    if (m_sum >= 7'd60) begin
      m_sum = m_sum - 7'd60;
      h_bin = (h_bin == 5'd23) ? 5'd0 : h_bin + 5'd1;
    end
    snz_tgt_m = {4'(m_sum / 7'd10), 4'(m_sum % 7'd10)};
    snz_tgt_h = {4'(h_bin / 5'd10), 4'(h_bin % 5'd10)};
  end

  // Snooze target reached: re-ring that channel.
  always_comb begin
    snz_hit = '0;
    for (int k = 0; k < NUM_ALARMS; k++)
      snz_hit[k] = snz_arm[k] & ~en & (cur_h == snz_h[k]) & (cur_m == snz_m[k]);
  end

  // Per-channel snooze arm/disarm; disarm wins over arming and hits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snz_arm <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        snz_h[k] <= 8'h00;
        snz_m[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if ((bt_c && !en) || en_rise || tog_off[k]) begin
          snz_arm[k] <= 1'b0;
        end else if (snz_press && ring[k]) begin
          snz_arm[k] <= 1'b1;
          snz_h[k]   <= snz_tgt_h;
          snz_m[k]   <= snz_tgt_m;
        end else if (snz_hit[k]) begin
          snz_arm[k] <= 1'b0;
        end
      end
    end
  end
`else
  assign snz_hit = '0;
  assign snz_clr = 1'b0;
`endif

endmodule
